// File: rtl/sd_loader_pkg.sv
// Shared types and sizes for the SD-card to RAM loader.
package sd_loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned LANE_WIDTH     = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    WRITE   = 3'd2,
    DRAIN   = 3'd3,
    DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/sd_ram_loader_if.sv
// Byte stream in (valid/ready/last) and Avalon-MM write master out.
interface sd_ram_loader_if
  import sd_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16
);

  logic [7:0]                st_data;
  logic                      st_valid;
  logic                      st_last;
  logic                      st_ready;

  logic [ADDR_WIDTH-1:0]     avm_address;
  logic                      avm_chipselect;
  logic                      avm_write;
  logic [DATA_WIDTH-1:0]     avm_writedata;
  logic [BYTES_PER_WORD-1:0] avm_byteenable;
  logic                      avm_waitrequest;

  // Loader side: consumes the stream, drives the RAM write port.
  modport master (
    input  st_data, st_valid, st_last, avm_waitrequest,
    output st_ready, avm_address, avm_chipselect, avm_write,
           avm_writedata, avm_byteenable
  );

  // Environment side: SD byte source and RAM slave.
  modport slave (
    output st_data, st_valid, st_last, avm_waitrequest,
    input  st_ready, avm_address, avm_chipselect, avm_write,
           avm_writedata, avm_byteenable
  );

endinterface

// File: rtl/sd_byte_packer.sv
// Packs bytes little-endian into one word, tracking filled lanes.
module sd_byte_packer
  import sd_loader_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      load,
  input  logic [7:0]                data,
  output logic [LANE_WIDTH-1:0]     lane,
  output logic [DATA_WIDTH-1:0]     writedata,
  output logic [BYTES_PER_WORD-1:0] byteenable
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane       <= '0;
      writedata  <= '0;
      byteenable <= '0;
    end else if (clear) begin
      lane       <= '0;
      writedata  <= '0;
      byteenable <= '0;
    end else if (load) begin
      writedata[32'(lane)*8 +: 8] <= data;
      byteenable[lane]            <= 1'b1;
      lane                        <= lane + LANE_WIDTH'(1);
    end
  end

endmodule

// File: rtl/sd_ram_loader.sv
// Streams SD-card bytes into the on-chip RAM as 32-bit words from a base address.
module sd_ram_loader
  import sd_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16
)(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_address,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [ADDR_WIDTH:0]   word_count,
  sd_ram_loader_if.master       bus
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_TOP = '1;

  state_t state, state_nxt;
  logic   busy_nxt, done_nxt, st_ready_nxt, write_nxt;
  logic   last_seen;
  logic   collect_beat_c, drain_beat_c, wr_done_c, start_c, pack_clear_c;
  logic [LANE_WIDTH-1:0] lane;

  assign start_c        = (state == IDLE) && start;
  assign collect_beat_c = (state == COLLECT) && bus.st_valid && bus.st_ready;
  assign drain_beat_c   = (state == DRAIN) && bus.st_valid && bus.st_ready;
  assign wr_done_c      = (state == WRITE) && !bus.avm_waitrequest;
  assign pack_clear_c   = start_c || wr_done_c;

  sd_byte_packer u_packer (
    .clk        (clk),
    .rst_n      (reset_n),
    .clear      (pack_clear_c),
    .load       (collect_beat_c),
    .data       (bus.st_data),
    .lane       (lane),
    .writedata  (bus.avm_writedata),
    .byteenable (bus.avm_byteenable)
  );

  // State register; Moore outputs are registered from the decoded next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= IDLE;
      busy               <= 1'b0;
      done               <= 1'b0;
      bus.st_ready       <= 1'b0;
      bus.avm_write      <= 1'b0;
      bus.avm_chipselect <= 1'b0;
    end else begin
      state              <= state_nxt;
      busy               <= busy_nxt;
      done               <= done_nxt;
      bus.st_ready       <= st_ready_nxt;
      bus.avm_write      <= write_nxt;
      bus.avm_chipselect <= write_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = COLLECT;
      COLLECT: begin
        if (collect_beat_c &&
            (lane == LANE_WIDTH'(BYTES_PER_WORD - 1) || bus.st_last))
          state_nxt = WRITE;
      end
      WRITE: begin
        if (wr_done_c) begin
          if (last_seen)                       state_nxt = DONE;
          else if (bus.avm_address == ADDR_TOP) state_nxt = DRAIN;
          else                                 state_nxt = COLLECT;
        end
      end
      DRAIN:   if (drain_beat_c && bus.st_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode of the upcoming state.
  always_comb begin
    busy_nxt     = 1'b0;
    done_nxt     = 1'b0;
    st_ready_nxt = 1'b0;
    write_nxt    = 1'b0;
    case (state_nxt)
      COLLECT: begin busy_nxt = 1'b1; st_ready_nxt = 1'b1; end
      WRITE:   begin busy_nxt = 1'b1; write_nxt    = 1'b1; end
      DRAIN:   begin busy_nxt = 1'b1; st_ready_nxt = 1'b1; end
      DONE:    done_nxt = 1'b1;
      default: ;
    endcase
  end

  // Address, word count, overflow and end-of-stream bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.avm_address <= '0;
      word_count      <= '0;
      overflow        <= 1'b0;
      last_seen       <= 1'b0;
    end else begin
      if (start_c) begin
        bus.avm_address <= base_address;
        word_count      <= '0;
        overflow        <= 1'b0;
        last_seen       <= 1'b0;
      end
      if (collect_beat_c) last_seen <= bus.st_last;
      if (wr_done_c) begin
        word_count <= word_count + (ADDR_WIDTH+1)'(1);
        if (!last_seen) begin
          if (bus.avm_address == ADDR_TOP) overflow <= 1'b1;
          else bus.avm_address <= bus.avm_address + ADDR_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sd_ram_loader.sv
// Directed bench for sd_ram_loader: vector table plus reset/idle corner sequences.
module tb_sd_ram_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] base_address;
  logic        busy, done, overflow;
  logic [16:0] word_count;

  sd_ram_loader_if #(.ADDR_WIDTH(16)) bus ();

  sd_ram_loader #(.ADDR_WIDTH(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .base_address (base_address),
    .busy         (busy),
    .done         (done),
    .overflow     (overflow),
    .word_count   (word_count),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] base;
    logic [31:0] nbytes;
    logic [7:0]  first;
    logic [31:0] stall;
    logic        poke;
    logic [31:0] nwr;
    logic [15:0] a0;
    logic [31:0] d0;
    logic [3:0]  be0;
    logic [15:0] a1;
    logic [31:0] d1;
    logic [3:0]  be1;
    logic [16:0] wc;
    logic        ovf;
    logic [15:0] fin;
  } vec_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  int   n_cmp = 0;
  int   n_fail = 0;
  wr_t  wr_log[$];
  int   hold_log[$];
  int   stall_left = 0;
  int   unstable = 0;
  int   rdy_wr = 0;
  int   cur_hold = 0;
  logic prev_stalled = 1'b0;
  wr_t  snap;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive waitrequest for the coming edge, observe the RAM port, then advance to the next negedge.
  task automatic step(output logic acc);
    wr_t cur;
    bus.avm_waitrequest = bus.avm_write && (stall_left > 0);
    if (bus.avm_waitrequest) stall_left--;
    acc = bus.st_valid && bus.st_ready;
    if (bus.avm_write) begin
      cur = '{addr: bus.avm_address, data: bus.avm_writedata, be: bus.avm_byteenable};
      if (prev_stalled && cur != snap) unstable++;
      if (bus.st_ready) rdy_wr++;
      cur_hold++;
      if (!bus.avm_waitrequest) begin
        wr_log.push_back(cur);
        hold_log.push_back(cur_hold);
        cur_hold     = 0;
        prev_stalled = 1'b0;
      end else begin
        prev_stalled = 1'b1;
        snap         = cur;
      end
    end
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l, input logic poke);
    logic acc;
    int   t;
    bus.st_data  = d;
    bus.st_valid = 1'b1;
    bus.st_last  = l;
    if (poke) begin
      start        = 1'b1;
      base_address = 16'hABCD;
    end
    acc = 1'b0;
    t   = 0;
    while (!acc && t < 50) begin
      step(acc);
      start = 1'b0;
      t++;
    end
    if (!acc) chk("byte_accept_timeout", 64'(acc), 64'(1));
    bus.st_valid = 1'b0;
    bus.st_last  = 1'b0;
  endtask

  task automatic clear_monitor();
    wr_log.delete();
    hold_log.delete();
    unstable     = 0;
    rdy_wr       = 0;
    cur_hold     = 0;
    prev_stalled = 1'b0;
  endtask

  task automatic pulse_start(input logic [15:0] b);
    logic a;
    start        = 1'b1;
    base_address = b;
    step(a);
    start        = 1'b0;
    base_address = '0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic a;
    int   t;
    clear_monitor();
    stall_left = int'(v.stall);
    pulse_start(v.base);
    chk($sformatf("v%0d_busy_after_start", idx), 64'(busy), 64'(1));
    chk($sformatf("v%0d_ovf_cleared", idx), 64'(overflow), 64'(0));
    chk($sformatf("v%0d_wc_cleared", idx), 64'(word_count), 64'(0));
    for (int i = 0; i < int'(v.nbytes); i++)
      send_byte(8'(v.first + 8'(i)), (i == int'(v.nbytes) - 1), v.poke && (i == 1));
    t = 0;
    while (!done && t < 50) begin
      step(a);
      t++;
    end
    chk($sformatf("v%0d_done_seen", idx), 64'(done), 64'(1));
    chk($sformatf("v%0d_busy_in_done", idx), 64'(busy), 64'(0));
    chk($sformatf("v%0d_word_count", idx), 64'(word_count), 64'(v.wc));
    chk($sformatf("v%0d_overflow", idx), 64'(overflow), 64'(v.ovf));
    chk($sformatf("v%0d_final_addr", idx), 64'(bus.avm_address), 64'(v.fin));
    step(a);
    chk($sformatf("v%0d_done_one_cycle", idx), 64'(done), 64'(0));
    chk($sformatf("v%0d_num_writes", idx), 64'(wr_log.size()), 64'(v.nwr));
    if (wr_log.size() >= 1) begin
      chk($sformatf("v%0d_w0_addr", idx), 64'(wr_log[0].addr), 64'(v.a0));
      chk($sformatf("v%0d_w0_data", idx), 64'(wr_log[0].data), 64'(v.d0));
      chk($sformatf("v%0d_w0_be", idx), 64'(wr_log[0].be), 64'(v.be0));
      chk($sformatf("v%0d_w0_hold", idx), 64'(hold_log[0]), 64'(v.stall + 1));
    end
    if (wr_log.size() >= 2 && v.nwr >= 2) begin
      chk($sformatf("v%0d_w1_addr", idx), 64'(wr_log[1].addr), 64'(v.a1));
      chk($sformatf("v%0d_w1_data", idx), 64'(wr_log[1].data), 64'(v.d1));
      chk($sformatf("v%0d_w1_be", idx), 64'(wr_log[1].be), 64'(v.be1));
    end
    chk($sformatf("v%0d_stall_stable", idx), 64'(unstable), 64'(0));
    chk($sformatf("v%0d_ready_in_write", idx), 64'(rdy_wr), 64'(0));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_overflow"}, 64'(overflow), 64'(0));
    chk({tag, "_word_count"}, 64'(word_count), 64'(0));
    chk({tag, "_st_ready"}, 64'(bus.st_ready), 64'(0));
    chk({tag, "_avm_write"}, 64'(bus.avm_write), 64'(0));
    chk({tag, "_avm_cs"}, 64'(bus.avm_chipselect), 64'(0));
    chk({tag, "_avm_address"}, 64'(bus.avm_address), 64'(0));
    chk({tag, "_avm_writedata"}, 64'(bus.avm_writedata), 64'(0));
    chk({tag, "_avm_byteenable"}, 64'(bus.avm_byteenable), 64'(0));
  endtask

  initial begin
    logic a;
    int   bad;
    int   t;

    vecs[0] = '{base:16'h0010, nbytes:8,  first:8'h01, stall:0, poke:1'b0, nwr:2,
                a0:16'h0010, d0:32'h04030201, be0:4'hF, a1:16'h0011, d1:32'h08070605, be1:4'hF,
                wc:17'd2, ovf:1'b0, fin:16'h0011};
    vecs[1] = '{base:16'h0000, nbytes:6,  first:8'hA0, stall:0, poke:1'b1, nwr:2,
                a0:16'h0000, d0:32'hA3A2A1A0, be0:4'hF, a1:16'h0001, d1:32'h0000A5A4, be1:4'h3,
                wc:17'd2, ovf:1'b0, fin:16'h0001};
    vecs[2] = '{base:16'h0100, nbytes:4,  first:8'h11, stall:3, poke:1'b0, nwr:1,
                a0:16'h0100, d0:32'h14131211, be0:4'hF, a1:16'h0, d1:32'h0, be1:4'h0,
                wc:17'd1, ovf:1'b0, fin:16'h0100};
    vecs[3] = '{base:16'hFFFF, nbytes:12, first:8'h30, stall:0, poke:1'b0, nwr:1,
                a0:16'hFFFF, d0:32'h33323130, be0:4'hF, a1:16'h0, d1:32'h0, be1:4'h0,
                wc:17'd1, ovf:1'b1, fin:16'hFFFF};
    vecs[4] = '{base:16'h0007, nbytes:1,  first:8'h5A, stall:0, poke:1'b0, nwr:1,
                a0:16'h0007, d0:32'h0000005A, be0:4'h1, a1:16'h0, d1:32'h0, be1:4'h0,
                wc:17'd1, ovf:1'b0, fin:16'h0007};
    vecs[5] = '{base:16'h0020, nbytes:4,  first:8'hC0, stall:0, poke:1'b0, nwr:1,
                a0:16'h0020, d0:32'hC3C2C1C0, be0:4'hF, a1:16'h0, d1:32'h0, be1:4'h0,
                wc:17'd1, ovf:1'b0, fin:16'h0020};

    reset_n             = 1'b0;
    start               = 1'b0;
    base_address        = '0;
    bus.st_data         = '0;
    bus.st_valid        = 1'b0;
    bus.st_last         = 1'b0;
    bus.avm_waitrequest = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;

    // Bytes offered with no start must never be taken.
    bus.st_valid = 1'b1;
    bus.st_data  = 8'h55;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      step(a);
      if (bus.st_ready || bus.avm_write || busy) bad++;
    end
    bus.st_valid = 1'b0;
    chk("idle_no_accept", 64'(bad), 64'(0));
    check_all_zero("idle");

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    // Abandon a stalled write with reset, then run a clean transfer.
    clear_monitor();
    stall_left = 100;
    pulse_start(16'h0040);
    for (int i = 0; i < 4; i++) send_byte(8'h90 + 8'(i), 1'b0, 1'b0);
    t = 0;
    while (!bus.avm_write && t < 20) begin
      step(a);
      t++;
    end
    step(a);
    chk("midwrite_write_active", 64'(bus.avm_write), 64'(1));
    reset_n = 1'b0;
    #1;
    chk("async_write_drop", 64'(bus.avm_write), 64'(0));
    stall_left          = 0;
    bus.avm_waitrequest = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    reset_n = 1'b1;
    step(a);
    run_vec(5, vecs[5]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_ram_loader.md
Name: sd_ram_loader

Overview:
- Upstream stage of the 64K x 32 on-chip RAM.
- Accepts the byte stream read from the SD card (valid/ready with last) and packs bytes little-endian into 32-bit words.
- Writes each word into the RAM through an Avalon-MM write master, starting at a software-supplied word address.
- Reports completion, number of words written, and address-space overflow.

Parameters:
- ADDR_WIDTH, 16, word-address width of the target RAM (65536 words).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a transfer; ignored while busy=1.
- base_address  in  ADDR_WIDTH  first word address; sampled on start.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse when the transfer completes.
- overflow  out  1  sticky; set when data arrives past the top RAM word; cleared by start.
- word_count  out  ADDR_WIDTH+1  words written this transfer; cleared by start.
- st_data  in  8  stream byte.
- st_valid  in  1  stream byte valid.
- st_last  in  1  marks the final byte; qualified by st_valid.
- st_ready  out  1  loader accepts a byte when st_valid & st_ready.
- avm_address  out  ADDR_WIDTH  word address.
- avm_chipselect  out  1  equal to avm_write.
- avm_write  out  1  write request.
- avm_writedata  out  32  packed word; byte n occupies bits [8n+7:8n].
- avm_byteenable  out  4  filled lanes.
- avm_waitrequest  in  1  stall; request is held stable while high.

Behaviour:
- Reset (asynchronous, reset_n=0): state IDLE; busy, done, overflow, st_ready, avm_write, avm_chipselect = 0; avm_address, avm_writedata, avm_byteenable, word_count, lane counter = 0.
- States: IDLE, COLLECT, WRITE, DRAIN, DONE.
- IDLE:
  - st_ready=0.
  - On start: latch base_address into avm_address; clear word_count, overflow, byteenable and writedata; lane=0; go to COLLECT.
- COLLECT:
  - st_ready=1.
  - On each accepted beat: writedata[lane] = st_data; byteenable[lane] = 1; lane++.
  - If lane was 3 or st_last=1: go to WRITE (st_ready=0 from the next cycle) and record last_seen = st_last.
- WRITE:
  - avm_write = avm_chipselect = 1; address, data and byteenable are held stable.
  - The write completes in the first cycle with avm_waitrequest=0.
  - On completion: word_count++; clear byteenable, writedata and lane.
  - If last_seen: go to DONE.
  - Else if avm_address = 2^ADDR_WIDTH-1: set overflow; go to DRAIN.
  - Else: avm_address++; go to COLLECT.
- DRAIN:
  - st_ready=1; accepted bytes are discarded; no RAM writes occur.
  - On the accepted beat with st_last: go to DONE.
- DONE:
  - done=1 for exactly one cycle; busy=0 in that cycle; go to IDLE.
  - avm_address keeps the last written address.
- Partial final word: only the filled lanes have byteenable set; unfilled writedata lanes are 0.
- Throughput: minimum 5 cycles per full word (4 accept cycles + 1 write cycle with no wait).
- start asserted while busy=1: ignored, with no effect on any state.
- st_valid with no st_last between transfers: not accepted, because st_ready=0 in IDLE.
- reset_n asserted mid-transfer: the transfer is abandoned at once; a write that was in progress is deasserted asynchronously.
- word_count saturates naturally: its maximum is 2^ADDR_WIDTH, which fits in ADDR_WIDTH+1 bits.

Decomposition:
- Package sd_loader_pkg:
  - state enum {IDLE, COLLECT, WRITE, DRAIN, DONE}.
  - BYTES_PER_WORD = 4.
  - DATA_WIDTH = 32.
- One sub-module, sd_byte_packer: lane counter, writedata and byteenable accumulation, plus a clear input. The FSM and Avalon master logic stay in the top level.

Test Plan:
- Reset then idle: st_valid=1 with no start → st_ready=0, avm_write never asserted, all outputs 0.
- start with base=0x0010; 8 bytes 0x01..0x08, last on the 8th; no waitrequest → writes 0x04030201 @0x0010 and 0x08070605 @0x0011, byteenable=0xF both; done pulse; word_count=2.
- base=0x0000; 6 bytes 0xA0..0xA5, last on the 6th → second write is 0x0000A5A4 with byteenable=0x3 @0x0001; word_count=2.
- avm_waitrequest high for 3 cycles on the first write → address, data and byteenable are stable for 4 cycles; st_ready=0 throughout; exactly one write is counted.
- base=0xFFFF; 12 bytes, last on the 12th → one write @0xFFFF; overflow=1; remaining 8 bytes drained with st_ready=1; done pulse; word_count=1; a following start clears overflow.
- reset_n low for 1 cycle mid-WRITE, then start with base=0x0020 and 4 bytes → all outputs are 0 after reset; the new transfer writes cleanly @0x0020 with word_count=1.
